// File: rtl/door_pkg.sv
// Shared types and defaults for the garage-door sequencer and its cycle timer.
package door_pkg;

    typedef enum logic [2:0] {
        ST_CLOSED  = 3'd0,
        ST_OPENING = 3'd1,
        ST_OPEN    = 3'd2,
        ST_CLOSING = 3'd3,
        ST_DEAD    = 3'd4,
        ST_FAULT   = 3'd5
    } door_state_e;

    localparam int DEAD_CYC_DEF      = 4;
    localparam int TRAVEL_MAX_DEF    = 1000;
    localparam int AUTOCLOSE_CYC_DEF = 2000;

    localparam int REQ_WALL   = 0;
    localparam int REQ_REMOTE = 1;
    localparam int NUM_REQ    = 2;

endpackage

// File: rtl/door_timer.sv
// Saturating cycle counter shared by the dead-time, travel-timeout and auto-close phases.
module door_timer #(
    parameter int TW = 16
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_clr,
    input  logic          i_en,
    input  logic [TW-1:0] i_tc_val,
    output logic          o_tc
);

    logic [TW-1:0] r_count;
    logic [TW:0]   w_count_inc;

    // Terminal count fires during the i_tc_val-th cycle, so a phase lasts exactly i_tc_val cycles.
    assign w_count_inc = {1'b0, r_count} + {{TW{1'b0}}, 1'b1};
    assign o_tc        = (w_count_inc >= {1'b0, i_tc_val});

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_en && !(&r_count)) begin
            r_count <= w_count_inc[TW-1:0];
        end
    end

endmodule

// File: rtl/door_sequencer.sv
// Door motor sequencer: FSM with enforced dead time before reversal, limit/obstruction
// handling, travel timeout fault, auto-close, and a two-input round-robin request arbiter.
module door_sequencer
    import door_pkg::*;
#(
    parameter int DEAD_CYC      = DEAD_CYC_DEF,
    parameter int TRAVEL_MAX    = TRAVEL_MAX_DEF,
    parameter int AUTOCLOSE_CYC = AUTOCLOSE_CYC_DEF,
    parameter int TW            = 16
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic [NUM_REQ-1:0] i_req,
    input  logic               i_obstruct,
    input  logic               i_up_max,
    input  logic               i_dn_max,
    output logic               o_up_motor,
    output logic               o_dn_motor,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic               o_fault,
    output logic [2:0]         o_state
);

    localparam logic [TW-1:0] DEAD_TC      = TW'(DEAD_CYC);
    localparam logic [TW-1:0] TRAVEL_TC    = TW'(TRAVEL_MAX);
    localparam logic [TW-1:0] AUTOCLOSE_TC = TW'(AUTOCLOSE_CYC);

    door_state_e        r_state;
    door_state_e        r_dir;
    logic               r_up_motor;
    logic               r_dn_motor;
    logic               r_fault;
    logic [NUM_REQ-1:0] r_gnt;
    logic               r_rr_ptr;

    door_state_e        w_next;
    door_state_e        w_rev_dir;
    logic               w_accept;
    logic               w_win;
    logic [NUM_REQ-1:0] w_gnt;
    logic               w_both_lim;
    logic               w_tc;
    logic               w_tmr_clr;
    logic               w_tmr_en;
    logic [TW-1:0]      w_tc_val;

    assign w_both_lim = i_up_max & i_dn_max;

    // A request only counts as accepted when it is the cause of the state change taken.
    always_comb begin
        w_next    = r_state;
        w_rev_dir = r_dir;
        w_accept  = 1'b0;
        case (r_state)
            ST_CLOSED: begin
                if (w_both_lim) begin
                    w_next = ST_FAULT;
                end else if (|i_req) begin
                    w_next   = ST_OPENING;
                    w_accept = 1'b1;
                end
            end
            ST_OPENING: begin
                if (w_both_lim) begin
                    w_next = ST_FAULT;
                end else if (i_up_max) begin
                    w_next = ST_OPEN;
                end else if (|i_req) begin
                    w_next    = ST_DEAD;
                    w_rev_dir = ST_CLOSING;
                    w_accept  = 1'b1;
                end else if (w_tc) begin
                    w_next = ST_FAULT;
                end
            end
            ST_OPEN: begin
                if (w_both_lim) begin
                    w_next = ST_FAULT;
                end else if (|i_req) begin
                    w_next   = ST_CLOSING;
                    w_accept = 1'b1;
                end else if (!i_obstruct && w_tc) begin
                    w_next = ST_CLOSING;
                end
            end
            ST_CLOSING: begin
                if (w_both_lim) begin
                    w_next = ST_FAULT;
                end else if (i_obstruct) begin
                    w_next    = ST_DEAD;
                    w_rev_dir = ST_OPENING;
                end else if (i_dn_max) begin
                    w_next = ST_CLOSED;
                end else if (|i_req) begin
                    w_next    = ST_DEAD;
                    w_rev_dir = ST_OPENING;
                    w_accept  = 1'b1;
                end else if (w_tc) begin
                    w_next = ST_FAULT;
                end
            end
            ST_DEAD: begin
                if (w_both_lim) begin
                    w_next = ST_FAULT;
                end else if (w_tc) begin
                    w_next = r_dir;
                end
            end
            ST_FAULT: begin
                w_next = ST_FAULT;
            end
            default: begin
                w_next = ST_FAULT;
            end
        endcase
    end

    // Both bits set defers to the pointer; a single bit always wins outright.
    assign w_win = (&i_req) ? r_rr_ptr : i_req[REQ_REMOTE];
    assign w_gnt = w_accept ? (NUM_REQ'(1) << w_win) : '0;

    always_comb begin
        w_tc_val = '1;
        case (r_state)
            ST_OPEN:    w_tc_val = AUTOCLOSE_TC;
            ST_OPENING: w_tc_val = TRAVEL_TC;
            ST_CLOSING: w_tc_val = TRAVEL_TC;
            ST_DEAD:    w_tc_val = DEAD_TC;
            default:    w_tc_val = '1;
        endcase
    end

    // An obstruction while open keeps the auto-close timer parked at zero.
    assign w_tmr_clr = (w_next != r_state) || ((r_state == ST_OPEN) && i_obstruct);
    assign w_tmr_en  = (r_state == ST_OPENING) || (r_state == ST_OPEN) ||
                       (r_state == ST_CLOSING) || (r_state == ST_DEAD);

    door_timer #(
        .TW (TW)
    ) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_clr    (w_tmr_clr),
        .i_en     (w_tmr_en),
        .i_tc_val (w_tc_val),
        .o_tc     (w_tc)
    );

    // Reset position follows the closed-limit switch; outputs are decoded from the next state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= i_dn_max ? ST_CLOSED : ST_OPEN;
            r_dir      <= ST_OPENING;
            r_up_motor <= 1'b0;
            r_dn_motor <= 1'b0;
            r_fault    <= 1'b0;
            r_gnt      <= '0;
            r_rr_ptr   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_dir      <= w_rev_dir;
            r_up_motor <= (w_next == ST_OPENING);
            r_dn_motor <= (w_next == ST_CLOSING);
            r_fault    <= (w_next == ST_FAULT);
            r_gnt      <= w_gnt;
            if (w_accept) begin
                r_rr_ptr <= ~w_win;
            end
        end
    end

    assign o_up_motor = r_up_motor;
    assign o_dn_motor = r_dn_motor;
    assign o_fault    = r_fault;
    assign o_gnt      = r_gnt;
    assign o_state    = r_state;

endmodule

// File: tb/tb_door_sequencer.sv
// Directed bench for door_sequencer: a vector table for the basic walk plus timed sequences.
module tb_door_sequencer;
    import door_pkg::*;

    logic       clk;
    logic       rstN;
    logic [1:0] req;
    logic       obstruct;
    logic       upMax;
    logic       dnMax;
    logic       upMotor;
    logic       dnMotor;
    logic [1:0] gnt;
    logic       fault;
    logic [2:0] state;

    int checkCount;
    int passCount;

    localparam logic [2:0] S_CLOSED  = 3'd0;
    localparam logic [2:0] S_OPENING = 3'd1;
    localparam logic [2:0] S_OPEN    = 3'd2;
    localparam logic [2:0] S_CLOSING = 3'd3;
    localparam logic [2:0] S_DEAD    = 3'd4;
    localparam logic [2:0] S_FAULT   = 3'd5;

    typedef struct packed {
        logic [1:0] req;
        logic       obs;
        logic       upMax;
        logic       dnMax;
        logic       expUp;
        logic       expDn;
        logic [1:0] expGnt;
        logic       expFault;
        logic [2:0] expState;
    } vec_t;

    vec_t vecs [19];

    door_sequencer dut (
        .i_clk      (clk),
        .i_rst_n    (rstN),
        .i_req      (req),
        .i_obstruct (obstruct),
        .i_up_max   (upMax),
        .i_dn_max   (dnMax),
        .o_up_motor (upMotor),
        .o_dn_motor (dnMotor),
        .o_gnt      (gnt),
        .o_fault    (fault),
        .o_state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [1:0] r, input logic o, input logic u, input logic d);
        req      = r;
        obstruct = o;
        upMax    = u;
        dnMax    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eUp, input logic eDn,
                               input logic [1:0] eGnt, input logic eFault, input logic [2:0] eState);
        logic [7:0] act;
        logic [7:0] exp;
        act = {upMotor, dnMotor, gnt, fault, state};
        exp = {eUp, eDn, eGnt, eFault, eState};
        checkCount++;
        if (act === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got up=%b dn=%b gnt=%b fault=%b state=%0d, want up=%b dn=%b gnt=%b fault=%b state=%0d",
                     name, upMotor, dnMotor, gnt, fault, state, eUp, eDn, eGnt, eFault, eState);
        end
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        rstN       = 1'b1;
        req        = 2'b00;
        obstruct   = 1'b0;
        upMax      = 1'b0;
        dnMax      = 1'b1;

        // req, obs, up, dn  ->  up, dn, gnt, fault, state
        vecs[0]  = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED};
        vecs[1]  = '{2'b11, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01, 1'b0, S_OPENING};
        vecs[2]  = '{2'b00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, S_OPENING};
        vecs[3]  = '{2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, S_OPEN};
        vecs[4]  = '{2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, S_OPEN};
        vecs[5]  = '{2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b10, 1'b0, S_CLOSING};
        vecs[6]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, S_CLOSING};
        vecs[7]  = '{2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b0, S_DEAD};
        vecs[8]  = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, S_DEAD};
        vecs[9]  = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, S_DEAD};
        vecs[10] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, S_DEAD};
        vecs[11] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, S_OPENING};
        vecs[12] = '{2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 1'b0, S_DEAD};
        vecs[13] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, S_DEAD};
        vecs[14] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, S_DEAD};
        vecs[15] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, S_DEAD};
        vecs[16] = '{2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b0, S_CLOSING};
        vecs[17] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED};
        vecs[18] = '{2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED};

        #2 rstN = 1'b0;
        #1 checkOutput("reset_closed", 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED);
        @(posedge clk);
        #1 rstN = 1'b1;

        for (int i = 0; i < 19; i++) begin
            applyStimulus(vecs[i].req, vecs[i].obs, vecs[i].upMax, vecs[i].dnMax);
            checkOutput($sformatf("vec%0d", i), vecs[i].expUp, vecs[i].expDn,
                        vecs[i].expGnt, vecs[i].expFault, vecs[i].expState);
        end

        // Obstruction beats limit switch and request while closing, then reverses after dead time.
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("obs_open_req", 1'b1, 1'b0, 2'b01, 1'b0, S_OPENING);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("obs_opened", 1'b0, 1'b0, 2'b00, 1'b0, S_OPEN);
        applyStimulus(2'b01, 1'b0, 1'b1, 1'b0);
        checkOutput("obs_close_req", 1'b0, 1'b1, 2'b01, 1'b0, S_CLOSING);
        applyStimulus(2'b01, 1'b1, 1'b0, 1'b1);
        checkOutput("obs_hit", 1'b0, 1'b0, 2'b00, 1'b0, S_DEAD);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
            checkOutput($sformatf("obs_dead%0d", i), 1'b0, 1'b0, 2'b00, 1'b0, S_DEAD);
        end
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("obs_reopen", 1'b1, 1'b0, 2'b00, 1'b0, S_OPENING);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("ac_opened", 1'b0, 1'b0, 2'b00, 1'b0, S_OPEN);

        // Auto-close: 2000 cycles in OPEN, closing drive on the next one.
        for (int i = 0; i < 1999; i++) applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("ac_still_open", 1'b0, 1'b0, 2'b00, 1'b0, S_OPEN);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("ac_closing", 1'b0, 1'b1, 2'b00, 1'b0, S_CLOSING);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("ac_closed", 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED);

        // An obstruction mid-wait restarts the full auto-close interval.
        applyStimulus(2'b10, 1'b0, 1'b0, 1'b1);
        checkOutput("hold_open_req", 1'b1, 1'b0, 2'b10, 1'b0, S_OPENING);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 1500; i++) applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 1999; i++) applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("hold_still_open", 1'b0, 1'b0, 2'b00, 1'b0, S_OPEN);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        checkOutput("hold_closing", 1'b0, 1'b1, 2'b00, 1'b0, S_CLOSING);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("hold_closed", 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED);

        // Travel timeout: 1000 cycles of opening with no limit switch.
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("to_opening", 1'b1, 1'b0, 2'b01, 1'b0, S_OPENING);
        for (int i = 0; i < 999; i++) applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("to_still_opening", 1'b1, 1'b0, 2'b00, 1'b0, S_OPENING);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("to_fault", 1'b0, 1'b0, 2'b00, 1'b1, S_FAULT);
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b0);
        checkOutput("to_fault_req_dropped", 1'b0, 1'b0, 2'b00, 1'b1, S_FAULT);
        dnMax = 1'b1;
        rstN  = 1'b0;
        #1 checkOutput("to_fault_reset", 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED);
        @(posedge clk);
        #1 rstN = 1'b1;

        // Both limits at once faults; reset with the door not closed comes up OPEN with pointer at bit0.
        applyStimulus(2'b01, 1'b0, 1'b0, 1'b1);
        checkOutput("lim_opening", 1'b1, 1'b0, 2'b01, 1'b0, S_OPENING);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b0);
        applyStimulus(2'b00, 1'b0, 1'b1, 1'b1);
        checkOutput("lim_both_fault", 1'b0, 1'b0, 2'b00, 1'b1, S_FAULT);
        upMax = 1'b1;
        dnMax = 1'b0;
        rstN  = 1'b0;
        #1 checkOutput("rst_to_open", 1'b0, 1'b0, 2'b00, 1'b0, S_OPEN);
        @(posedge clk);
        #1 rstN = 1'b1;
        applyStimulus(2'b11, 1'b0, 1'b1, 1'b0);
        checkOutput("rr_ptr_reset", 1'b0, 1'b1, 2'b01, 1'b0, S_CLOSING);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b0);
        checkOutput("mid_closing", 1'b0, 1'b1, 2'b00, 1'b0, S_CLOSING);
        #3 rstN = 1'b0;
        #1 checkOutput("async_stop", 1'b0, 1'b0, 2'b00, 1'b0, S_OPEN);
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("rst_follow_dnmax", 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED);
        rstN = 1'b1;
        applyStimulus(2'b00, 1'b0, 1'b0, 1'b1);
        checkOutput("final_closed", 1'b0, 1'b0, 2'b00, 1'b0, S_CLOSED);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
